matrix_reader: RTL and testbench



---
 rtl/matrix_pkg.sv | 20 ++
 rtl/matrix_addr_gen.sv | 74 +++++++
 rtl/matrix_reader.sv | 114 +++++++++++
 tb/tb_matrix_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix buffer read sequencer.
package matrix_pkg;

    typedef enum logic {
        ORDER_ROW = 1'b0,
        ORDER_COL = 1'b1
    } order_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_e;

    // Index width for a counter spanning 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_addr_gen.sv
// Outer/inner element counters with line/last flags and the row-major address
// they map to; counters step once per asserted advance.
module matrix_addr_gen
    import matrix_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          col_major,
    input  logic [AW-1:0] base,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          line_last,
    output logic          last
);

    localparam int IW = (idx_width(ROWS) > idx_width(COLS)) ? idx_width(ROWS) : idx_width(COLS);

    logic [IW-1:0] outer_reg;
    logic [IW-1:0] inner_reg;
    logic [AW-1:0] base_reg;
    order_e        order_reg;

    logic [IW-1:0] inner_max;
    logic [IW-1:0] outer_max;
    logic [IW-1:0] row;
    logic [IW-1:0] col;

    always_comb begin
        inner_max = IW'(COLS - 1);
        outer_max = IW'(ROWS - 1);
        row       = outer_reg;
        col       = inner_reg;
        if (order_reg == ORDER_COL) begin
            inner_max = IW'(ROWS - 1);
            outer_max = IW'(COLS - 1);
            row       = inner_reg;
            col       = outer_reg;
        end
    end

    assign line_last = (inner_reg == inner_max);
    assign last      = line_last && (outer_reg == outer_max);

    // AW-bit arithmetic: overflow past the top of memory wraps to address 0.
    assign addr = base_reg + AW'(row) * AW'(COLS) + AW'(col);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outer_reg <= '0;
            inner_reg <= '0;
            base_reg  <= '0;
            order_reg <= ORDER_ROW;
        end else if (clear) begin
            outer_reg <= '0;
            inner_reg <= '0;
            base_reg  <= base;
            order_reg <= col_major ? ORDER_COL : ORDER_ROW;
        end else if (advance) begin
            if (line_last) begin
                inner_reg <= '0;
                outer_reg <= (outer_reg == outer_max) ? '0 : outer_reg + 1'b1;
            end else begin
                inner_reg <= inner_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_reader.sv
// Read sequencer: walks a ROWS x COLS matrix in buffer memory and streams it
// out row-major or column-major over a valid/ready interface.
module matrix_reader
    import matrix_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 col_major_i,
    input  logic [AW-1:0]        base_i,
    output logic [AW-1:0]        r_addr_o,
    input  logic [DATA_SIZE-1:0] r_data_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 line_last_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    state_e               state_reg;
    logic [DATA_SIZE-1:0] data_reg;
    logic                 valid_reg;
    logic                 line_last_reg;
    logic                 last_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic accept;
    logic load;
    logic fire;
    logic gen_line_last;
    logic gen_last;

    // A start coinciding with the done pulse is deliberately dropped.
    assign accept = (state_reg == IDLE) && start_i && !done_reg;
    assign load   = (state_reg == FETCH) && (!valid_reg || ready_i);
    assign fire   = valid_reg && ready_i;

    matrix_addr_gen #(
        .DEPTH (DEPTH),
        .ROWS  (ROWS),
        .COLS  (COLS)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .col_major (col_major_i),
        .base      (base_i),
        .advance   (load),
        .addr      (r_addr_o),
        .line_last (gen_line_last),
        .last      (gen_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            line_last_reg <= 1'b0;
            last_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        busy_reg  <= 1'b1;
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (load) begin
                        data_reg      <= r_data_i;
                        valid_reg     <= 1'b1;
                        line_last_reg <= gen_line_last;
                        last_reg      <= gen_last;
                        if (gen_last) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        valid_reg     <= 1'b0;
                        line_last_reg <= 1'b0;
                        last_reg      <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign data_o      = data_reg;
    assign valid_o     = valid_reg;
    assign line_last_o = line_last_reg;
    assign last_o      = last_reg;
    assign busy_o      = busy_reg;
    assign done_o      = done_reg;

endmodule

// File: tb/tb_matrix_reader.sv
// Self-checking bench for matrix_reader: 2x3 matrix in a 16-entry memory,
// expected streams generated from the matrix walk order.
module tb_matrix_reader;

    localparam int DATA_SIZE = 8;
    localparam int DEPTH     = 16;
    localparam int ROWS      = 2;
    localparam int COLS      = 3;
    localparam int AW        = $clog2(DEPTH);
    localparam int N         = ROWS * COLS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start_i = 1'b0;
    logic                 col_major_i = 1'b0;
    logic [AW-1:0]        base_i = '0;
    logic [AW-1:0]        r_addr_o;
    logic [DATA_SIZE-1:0] r_data_i;
    logic [DATA_SIZE-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i = 1'b0;
    logic                 line_last_o;
    logic                 last_o;
    logic                 busy_o;
    logic                 done_o;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    int errors = 0;
    int checks = 0;

    logic [DATA_SIZE-1:0] exp_data [$];
    logic                 exp_ll   [$];
    logic                 exp_last [$];

    always #5 clk = ~clk;

    assign r_data_i = mem[r_addr_o];

    matrix_reader #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .col_major_i (col_major_i),
        .base_i      (base_i),
        .r_addr_o    (r_addr_o),
        .r_data_i    (r_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .line_last_o (line_last_o),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Reference walk: element (row, col) lives at (base + row*COLS + col) mod DEPTH.
    task automatic build_expected(input int base, input bit cm);
        int n_outer, n_inner, row, col, addr;
        exp_data.delete();
        exp_ll.delete();
        exp_last.delete();
        n_outer = cm ? COLS : ROWS;
        n_inner = cm ? ROWS : COLS;
        for (int o = 0; o < n_outer; o++) begin
            for (int i = 0; i < n_inner; i++) begin
                row  = cm ? i : o;
                col  = cm ? o : i;
                addr = (base + row * COLS + col) % DEPTH;
                exp_data.push_back(mem[addr]);
                exp_ll.push_back(i == n_inner - 1);
                exp_last.push_back((i == n_inner - 1) && (o == n_outer - 1));
            end
        end
    endtask

    // mode: 0 = ready always 1, 1 = fixed stall pattern, 2 = random ready.
    task automatic run_stream(input string name, input int base, input bit cm,
                              input int mode, input bit restart_mid, input int abort_after);
        int beat, cyc, done_cnt;
        bit r, prev_stall, prev_ll, prev_last;
        logic [DATA_SIZE-1:0] prev_data;
        bit pattern [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        build_expected(base, cm);
        @(negedge clk);
        start_i = 1'b1;
        base_i = AW'(base);
        col_major_i = cm;
        ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || valid_o !== 1'b0 || r_addr_o !== AW'(base)) begin
            errors++;
            $display("FAIL %s start: busy=%b valid=%b addr=%0d, required busy=1 valid=0 addr=%0d",
                     name, busy_o, valid_o, r_addr_o, base);
        end
        @(negedge clk);
        beat = 0; cyc = 0; done_cnt = 0; prev_stall = 0;
        prev_data = '0; prev_ll = 0; prev_last = 0;
        while (beat < N && cyc < 200) begin
            if (done_o === 1'b1) done_cnt++;
            if (prev_stall) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== prev_data || last_o !== prev_last || line_last_o !== prev_ll) begin
                    errors++;
                    $display("FAIL %s stall_hold cyc%0d: valid=%b data=%h last=%b ll=%b, required 1 %h %b %b",
                             name, cyc, valid_o, data_o, last_o, line_last_o, prev_data, prev_last, prev_ll);
                end
            end
            if (mode == 0) begin
                checks++;
                if (valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s no_bubble cyc%0d: valid=%b, required 1", name, cyc, valid_o);
                end
            end
            case (mode)
                0: r = 1'b1;
                1: r = pattern[cyc % 6];
                default: r = 1'($urandom_range(0, 1));
            endcase
            ready_i = r;
            if (restart_mid && cyc == 2) begin
                start_i = 1'b1;
                base_i = 5;
                col_major_i = ~cm;
            end else begin
                start_i = 1'b0;
            end
            if (valid_o === 1'b1 && r) begin
                checks++;
                if (data_o !== exp_data[beat] || line_last_o !== exp_ll[beat] || last_o !== exp_last[beat]) begin
                    errors++;
                    $display("FAIL %s beat%0d: data=%h ll=%b last=%b, required data=%h ll=%b last=%b",
                             name, beat, data_o, line_last_o, last_o, exp_data[beat], exp_ll[beat], exp_last[beat]);
                end
                beat++;
                if (abort_after != 0 && beat == abort_after) begin
                    @(negedge clk);
                    rst_n = 1'b0;
                    ready_i = 1'b0;
                    start_i = 1'b0;
                    @(negedge clk);
                    checks++;
                    if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || last_o !== 1'b0 ||
                        data_o !== '0 || r_addr_o !== '0) begin
                        errors++;
                        $display("FAIL %s abort: valid=%b busy=%b done=%b last=%b data=%h addr=%0d, required all 0",
                                 name, valid_o, busy_o, done_o, last_o, data_o, r_addr_o);
                    end
                    rst_n = 1'b1;
                    @(negedge clk);
                    checks++;
                    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                        errors++;
                        $display("FAIL %s abort_idle: done=%b busy=%b, required 0 0", name, done_o, busy_o);
                    end
                    $display("%s: aborted after %0d beats", name, beat);
                    return;
                end
            end
            prev_stall = (valid_o === 1'b1) && !r;
            prev_data = data_o;
            prev_ll = line_last_o;
            prev_last = last_o;
            cyc++;
            @(negedge clk);
        end
        start_i = 1'b0;
        ready_i = 1'b0;
        col_major_i = cm;
        checks++;
        if (beat != N || done_cnt != 0) begin
            errors++;
            $display("FAIL %s completion: beats=%0d early_done=%0d, required beats=%0d early_done=0",
                     name, beat, done_cnt, N);
        end
        checks++;
        if (done_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b valid=%b busy=%b, required 1 0 0", name, done_o, valid_o, busy_o);
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b, required 0 0 (start with done ignored)",
                     name, done_o, busy_o);
        end
        $display("%s: base=%0d order=%0d mode=%0d beats=%0d cycles=%0d", name, base, cm, mode, beat, cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || last_o !== 1'b0 || line_last_o !== 1'b0 || busy_o !== 1'b0 ||
            done_o !== 1'b0 || data_o !== '0 || r_addr_o !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b last=%b ll=%b busy=%b done=%b data=%h addr=%0d, required all 0",
                     valid_o, last_o, line_last_o, busy_o, done_o, data_o, r_addr_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic fill_linear();
        for (int k = 0; k < DEPTH; k++) mem[k] = DATA_SIZE'(8'h10 + k);
    endtask

    task automatic test_row_major();      run_stream("row_major", 0, 1'b0, 0, 1'b0, 0); endtask
    task automatic test_col_major();      run_stream("col_major", 0, 1'b1, 0, 1'b0, 0); endtask
    task automatic test_wrap();           run_stream("wrap", 14, 1'b0, 0, 1'b0, 0); endtask
    task automatic test_stall();          run_stream("stall", 0, 1'b0, 1, 1'b0, 0); endtask
    task automatic test_restart_ignored(); run_stream("restart_ignored", 0, 1'b0, 0, 1'b1, 0); endtask

    task automatic test_abort_replay();
        run_stream("abort", 0, 1'b0, 0, 1'b0, 3);
        run_stream("replay", 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < DEPTH; k++) mem[k] = DATA_SIZE'($urandom);
            run_stream("random", int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)),
                       2, 1'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        fill_linear();
        test_reset();
        test_row_major();
        test_col_major();
        test_wrap();
        test_stall();
        test_restart_ignored();
        test_abort_replay();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
